// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the pipeline stages: reset fetch address,
// instruction width, fetch FSM encodings and an alignment helper.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic {
    ST_FETCH     = 1'b0,
    ST_WAIT_MISS = 1'b1
  } fetch_state_e;

  // Word-align an address by clearing the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module fetch_stage_sat_counter
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: increment only while below the saturation value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: presents pc to the icache, captures the word on a
// hit, waits on a miss, and follows redirects with word alignment.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_FETCH     | pc presented to icache, a hit is expected
// ST_WAIT_MISS | pc presented again, the previous lookup missed
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        icache_addr,
  input  logic [INSTR_W-1:0] icache_data,
  input  logic               icache_hit,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc_out,
  output logic [31:0]        npc_out,
  output logic               valid,
  output logic               fetch_err,
  output logic [31:0]        miss_cycles,
  output logic [31:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic [31:0]        npc_out_q, npc_out_d;
  logic               valid_q, valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic               miss_inc;
  logic               fetch_inc;

  // Next-state: redirect beats stall, stall beats hit, hit beats miss.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    npc_out_d   = npc_out_q;
    valid_d     = valid_q;
    fetch_err_d = 1'b0;
    miss_inc    = 1'b0;
    fetch_inc   = 1'b0;
    if (redirect) begin
      pc_d        = align_word(redirect_pc);
      valid_d     = 1'b0;
      state_d     = ST_FETCH;
      fetch_err_d = |redirect_pc[1:0];
    end else if (stall) begin
      // everything holds, including the counters
    end else if (icache_hit) begin
      instr_d   = icache_data;
      pc_out_d  = pc_q;
      npc_out_d = pc_q + 32'd4;
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
      state_d   = ST_FETCH;
      fetch_inc = 1'b1;
    end else begin
      valid_d  = 1'b0;
      state_d  = ST_WAIT_MISS;
      miss_inc = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= align_word(RESET_PC);
      instr_q     <= '0;
      pc_out_q    <= '0;
      npc_out_q   <= '0;
      valid_q     <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      npc_out_q   <= npc_out_d;
      valid_q     <= valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  fetch_stage_sat_counter u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_cycles)
  );

  fetch_stage_sat_counter u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_inc),
    .count (fetch_count)
  );

  // icache_addr comes straight from the pc register only.
  assign icache_addr = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign npc_out     = npc_out_q;
  assign valid       = valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 icache_addr  output  32  fetch address presented to icache; combinational copy of internal pc register.
REQ-005 icache_data  input  32  instruction word returned by icache; meaningful only when icache_hit=1.
REQ-006 icache_hit  input  1  icache lookup result for icache_addr in the current cycle.
REQ-007 stall  input  1  decode/hazard back-pressure; output register and pc must hold.
REQ-008 redirect  input  1  branch/jump/exception redirect request, single-cycle pulse.
REQ-009 redirect_pc  input  32  redirect target, sampled when redirect=1.
REQ-010 instr  output  32  fetched instruction to decode.
REQ-011 pc_out  output  32  address of instr.
REQ-012 npc_out  output  32  pc_out+4, modulo 2^32.
REQ-013 valid  output  1  instr/pc_out/npc_out hold a real instruction.
REQ-014 fetch_err  output  1  one-cycle pulse: redirect_pc was misaligned.
REQ-015 miss_cycles  output  32  count of cycles spent in WAIT_MISS, saturating at 32'hFFFFFFFF.
REQ-016 fetch_count  output  32  count of instructions delivered (valid rising into output register), saturating.

Function
REQ-017 Two-state FSM: FETCH (pc presented, expecting hit) and WAIT_MISS (pc presented, previous cycle missed).
REQ-018 Per-edge priority: reset > redirect > stall > hit > miss.
REQ-019 redirect: pc <= {redirect_pc[31:2],2'b00}; valid <= 0; state <= FETCH; instr/pc_out/npc_out hold; applies even when stall=1 or state=WAIT_MISS.
REQ-020 redirect with redirect_pc[1:0]!=0: fetch_err=1 on the following cycle only; otherwise fetch_err=0.
REQ-021 stall (no redirect): pc, state, instr, pc_out, npc_out, valid all hold; counters hold.
REQ-022 hit (no redirect, no stall): instr <= icache_data; pc_out <= pc; npc_out <= pc+4; valid <= 1; pc <= pc+4; state <= FETCH; fetch_count increments.
REQ-023 miss (no redirect, no stall, icache_hit=0): valid <= 0; pc holds; state <= WAIT_MISS; miss_cycles increments.
REQ-024 Hit latency: instruction appears on instr one clock edge after icache_hit=1 with matching icache_addr; back-to-back hits deliver one instruction per cycle.
REQ-025 pc arithmetic 32-bit modulo: pc=32'hFFFFFFFC + hit -> pc=32'h00000000, npc_out=32'h00000000.
REQ-026 Counters saturate; never wrap to zero.
REQ-027 icache_addr[1:0] always 2'b00.

Reset
REQ-028 On reset edge: pc=RESET_PC, state=FETCH, valid=0, instr=32'h00000000, pc_out=0, npc_out=0, fetch_err=0, miss_cycles=0, fetch_count=0.
REQ-029 Reset asserted mid-miss or mid-stall overrides all other inputs in that cycle; no instruction delivered on that edge.
REQ-030 First fetch after reset deassertion presents RESET_PC on icache_addr in the same cycle.

Structure
REQ-031 RESET_PC default, instruction width (32) and FSM state encodings live in the shared defines header included by all pipeline stages.
REQ-032 Single optional sub-module: sat_counter (32-bit saturating incrementer), instantiated twice for miss_cycles and fetch_count.
REQ-033 No combinational path from stall/redirect to icache_addr; icache_addr depends only on pc register.

Verification
REQ-034 Reset, icache_hit=1 constant, 3 cycles -> instr/pc_out sequence 0x00400000, 0x00400004, 0x00400008, valid=1 from second edge, fetch_count=3.
REQ-035 icache_hit=0 for 4 cycles at 0x00400004 then 1 -> valid=0 for 4 cycles, miss_cycles=4, then pc_out=0x00400004 valid=1.
REQ-036 stall=1 for 2 cycles with hit=1 -> instr/pc_out/valid unchanged, icache_addr unchanged, counters unchanged.
REQ-037 redirect=1, redirect_pc=0x0030e042 while stall=1 and in WAIT_MISS -> next icache_addr=0x0030e040, valid=0, fetch_err=1 for exactly one cycle.
REQ-038 Redirect to 0xFFFFFFFC, hit=1 two cycles -> pc_out 0xFFFFFFFC then 0x00000000, npc_out 0x00000000 then 0x00000004.
REQ-039 reset asserted during miss with miss_cycles=7 -> all outputs at REQ-028 values next edge, icache_addr=0x00400000.
